// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the ASCON-128a control path.
// Optional AD-skip support in the controller is enabled with ASCON_AD_SKIP_EN.
package ascon_pack;

  localparam int ROUNDS_A_C = 12;
  localparam int ROUNDS_B_C = 8;
  localparam logic [3:0] ROUND_LAST_C = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_AD,
    ST_AD,
    ST_WAIT_PT,
    ST_PT,
    ST_FINAL,
    ST_DONE
  } type_ctrl_state;

  // First round-constant index of a permutation with the given round count.
  function automatic logic [3:0] round_start(input int rounds);
    return 4'(ROUNDS_A_C - rounds);
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round-constant index counter: load of one of two start values, increment, hold.
module round_counter #(
  parameter logic [3:0] START_A = 4'd0,
  parameter logic [3:0] START_B = 4'd4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       en_i,
  input  logic       load_a_i,
  input  logic       load_b_i,
  output logic [3:0] count_o
);

  logic [3:0] count_d;
  logic [3:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load_a_i) begin
      count_d = START_A;
    end else if (load_b_i) begin
      count_d = START_B;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Moore control FSM for the ASCON-128a datapath (init, one AD block, PT blocks, final).
// Define ASCON_AD_SKIP_EN to add ad_skip_i, which bypasses the AD phase.
//   state      | meaning
//   IDLE       | waiting for start_i
//   INIT       | p^a over IV||K||N
//   WAIT_AD    | waiting for the AD block
//   AD         | p^b over the AD block
//   WAIT_PT    | waiting for a plaintext block
//   PT         | p^b over a non-final plaintext block
//   FINAL      | p^a over the final block, key injected
//   DONE       | tag valid for one cycle
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_C,
  parameter int ROUNDS_B = ROUNDS_B_C
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_i,
`ifdef ASCON_AD_SKIP_EN
  input  logic       ad_skip_i,
`endif
  output logic       init_state_o,
  output logic       en_reg_state_o,
  output logic       en_xor_begin_data_o,
  output logic       en_xor_begin_key_o,
  output logic       en_xor_end_key_o,
  output logic       en_xor_end_lsb_o,
  output logic [3:0] round_o,
  output logic       data_ready_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  localparam logic [3:0] START_A = round_start(ROUNDS_A);
  localparam logic [3:0] START_B = round_start(ROUNDS_B);

  type_ctrl_state state_d;
  type_ctrl_state state_q;
  logic [3:0]     cnt;
  logic           cnt_en;
  logic           load_a;
  logic           load_b;
  logic           ad_skip_q;
  logic           last_round;

  round_counter #(
    .START_A (START_A),
    .START_B (START_B)
  ) u_round_counter (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .en_i     (cnt_en),
    .load_a_i (load_a),
    .load_b_i (load_b),
    .count_o  (cnt)
  );

`ifdef ASCON_AD_SKIP_EN
  logic ad_skip_d;

  always_comb begin
    ad_skip_d = ad_skip_q;
    if (state_q == ST_IDLE && start_i) begin
      ad_skip_d = ad_skip_i;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      ad_skip_q <= 1'b0;
    end else begin
      ad_skip_q <= ad_skip_d;
    end
  end
`else
  assign ad_skip_q = 1'b0;
`endif

  assign last_round = (cnt == ROUND_LAST_C);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend only on registered state/counter, so reset clears them at once.
  always_comb begin
    state_d             = state_q;
    cnt_en              = 1'b0;
    load_a              = 1'b0;
    load_b              = 1'b0;
    init_state_o        = 1'b0;
    en_reg_state_o      = 1'b0;
    en_xor_begin_data_o = 1'b0;
    en_xor_begin_key_o  = 1'b0;
    en_xor_end_key_o    = 1'b0;
    en_xor_end_lsb_o    = 1'b0;
    round_o             = 4'd0;
    data_ready_o        = 1'b0;
    cipher_valid_o      = 1'b0;
    tag_valid_o         = 1'b0;
    busy_o              = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          load_a  = 1'b1;
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        en_reg_state_o = 1'b1;
        round_o        = cnt;
        init_state_o   = (cnt == START_A);
        if (last_round) begin
          en_xor_end_key_o = 1'b1;
          en_xor_end_lsb_o = ad_skip_q;
          state_d          = ad_skip_q ? ST_WAIT_PT : ST_WAIT_AD;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_WAIT_AD: begin
        if (data_valid_i) begin
          load_b  = 1'b1;
          state_d = ST_AD;
        end
      end

      ST_AD: begin
        en_reg_state_o      = 1'b1;
        round_o             = cnt;
        en_xor_begin_data_o = (cnt == START_B);
        data_ready_o        = (cnt == START_B);
        if (last_round) begin
          en_xor_end_lsb_o = 1'b1;
          state_d          = ST_WAIT_PT;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_WAIT_PT: begin
        if (data_valid_i) begin
          if (last_i) begin
            load_a  = 1'b1;
            state_d = ST_FINAL;
          end else begin
            load_b  = 1'b1;
            state_d = ST_PT;
          end
        end
      end

      ST_PT: begin
        en_reg_state_o      = 1'b1;
        round_o             = cnt;
        en_xor_begin_data_o = (cnt == START_B);
        data_ready_o        = (cnt == START_B);
        cipher_valid_o      = (cnt == START_B);
        if (last_round) begin
          state_d = ST_WAIT_PT;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_FINAL: begin
        en_reg_state_o      = 1'b1;
        round_o             = cnt;
        en_xor_begin_data_o = (cnt == START_A);
        en_xor_begin_key_o  = (cnt == START_A);
        data_ready_o        = (cnt == START_A);
        cipher_valid_o      = (cnt == START_A);
        if (last_round) begin
          en_xor_end_key_o = 1'b1;
          state_d          = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_DONE: begin
        tag_valid_o = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        busy_o  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Scoreboard bench for ascon_ctrl_fsm: expected output vectors are queued per cycle
// when stimulus is driven and compared at the following falling edges.
module tb_ascon_ctrl_fsm;

  localparam int RB = 8;
  localparam int B0 = 12 - RB;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic       last_i = 1'b0;
`ifdef ASCON_AD_SKIP_EN
  logic       ad_skip_i = 1'b0;
`endif
  logic       init_state_o;
  logic       en_reg_state_o;
  logic       en_xor_begin_data_o;
  logic       en_xor_begin_key_o;
  logic       en_xor_end_key_o;
  logic       en_xor_end_lsb_o;
  logic [3:0] round_o;
  logic       data_ready_o;
  logic       cipher_valid_o;
  logic       tag_valid_o;
  logic       busy_o;

  int n_vec = 0;
  int n_err = 0;
  logic [13:0] exp_q[$];

  always #5 clock_i = ~clock_i;

  ascon_ctrl_fsm dut (
    .clock_i             (clock_i),
    .resetb_i            (resetb_i),
    .start_i             (start_i),
    .data_valid_i        (data_valid_i),
    .last_i              (last_i),
`ifdef ASCON_AD_SKIP_EN
    .ad_skip_i           (ad_skip_i),
`endif
    .init_state_o        (init_state_o),
    .en_reg_state_o      (en_reg_state_o),
    .en_xor_begin_data_o (en_xor_begin_data_o),
    .en_xor_begin_key_o  (en_xor_begin_key_o),
    .en_xor_end_key_o    (en_xor_end_key_o),
    .en_xor_end_lsb_o    (en_xor_end_lsb_o),
    .round_o             (round_o),
    .data_ready_o        (data_ready_o),
    .cipher_valid_o      (cipher_valid_o),
    .tag_valid_o         (tag_valid_o),
    .busy_o              (busy_o)
  );

  // {init, en_reg, xb_data, xb_key, xe_key, xe_lsb, round[3:0], ready, cipher, tag, busy}
  function automatic logic [13:0] ov(bit i, bit r, bit xd, bit xk, bit ek, bit el,
                                     int rnd, bit rdy, bit cv, bit tv, bit b);
    logic [3:0] rr;
    rr = 4'(rnd);
    return {i, r, xd, xk, ek, el, rr, rdy, cv, tv, b};
  endfunction

  function logic [13:0] obs();
    return {init_state_o, en_reg_state_o, en_xor_begin_data_o, en_xor_begin_key_o,
            en_xor_end_key_o, en_xor_end_lsb_o, round_o, data_ready_o, cipher_valid_o,
            tag_valid_o, busy_o};
  endfunction

  function automatic void push_init(bit skip);
    for (int r = 0; r < 12; r++)
      exp_q.push_back(ov(r == 0, 1, 0, 0, r == 11, skip && r == 11, r, 0, 0, 0, 1));
  endfunction

  function automatic void push_block(bit is_ad);
    for (int r = B0; r < 12; r++)
      exp_q.push_back(ov(0, 1, r == B0, 0, 0, is_ad && r == 11, r, r == B0,
                         !is_ad && r == B0, 0, 1));
  endfunction

  function automatic void push_final();
    for (int r = 0; r < 12; r++)
      exp_q.push_back(ov(0, 1, r == 0, r == 0, r == 11, 0, r, r == 0, r == 0, 0, 1));
  endfunction

  function automatic void push_wait(int n);
    for (int k = 0; k < n; k++) exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
  endfunction

  function automatic void push_done();
    exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
  endfunction

  function automatic void push_idle(int n);
    for (int k = 0; k < n; k++) exp_q.push_back(14'd0);
  endfunction

  task automatic test_reset();
    logic [13:0] e;
    resetb_i = 1'b0;
    start_i  = 1'b1;
    push_idle(3);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL reset_hold: got %h expected %h", obs(), e);
      end
    end
    start_i  = 1'b0;
    resetb_i = 1'b1;
    push_idle(2);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL reset_idle: got %h expected %h", obs(), e);
      end
    end
  endtask

  task automatic test_init();
    logic [13:0] e;
    start_i = 1'b1;
    push_init(0);
    push_wait(1);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      start_i = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL init: got %h expected %h", obs(), e);
      end
    end
  endtask

  task automatic test_wait_hold();
    logic [13:0] e;
    start_i = 1'b1;
    push_wait(3);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL wait_hold: got %h expected %h", obs(), e);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_ad();
    logic [13:0] e;
    data_valid_i = 1'b1;
    push_block(1);
    push_wait(1);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      data_valid_i = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL ad_block: got %h expected %h", obs(), e);
      end
    end
  endtask

  task automatic test_pt();
    logic [13:0] e;
    for (int blk = 0; blk < 2; blk++) begin
      data_valid_i = 1'b1;
      last_i       = 1'b0;
      push_block(0);
      push_wait(1);
      while (exp_q.size() > 0) begin
        @(negedge clock_i);
        data_valid_i = 1'b0;
        e = exp_q.pop_front();
        n_vec++;
        if (obs() !== e) begin
          n_err++;
          $display("FAIL pt_block%0d: got %h expected %h", blk, obs(), e);
        end
      end
    end
  endtask

  task automatic test_final();
    logic [13:0] e;
    data_valid_i = 1'b1;
    last_i       = 1'b1;
    push_final();
    push_done();
    push_idle(2);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      data_valid_i = 1'b0;
      last_i       = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL final: got %h expected %h", obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int tags;
    bit seen;
    start_i      = 1'b1;
    data_valid_i = 1'b1;
    last_i       = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clock_i);
      start_i = 1'b0;
      n++;
      if (tag_valid_o === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || n != 35) begin
      n_err++;
      $display("FAIL latency: got %0d cycles (seen=%0d) expected 35", n, seen);
    end
    tags = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock_i);
      if (tag_valid_o === 1'b1) tags++;
    end
    data_valid_i = 1'b0;
    last_i       = 1'b0;
    n_vec++;
    if (tags != 0 || obs() !== 14'd0) begin
      n_err++;
      $display("FAIL tag_once: extra tags %0d, outputs %h expected 0000", tags, obs());
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e;
    start_i = 1'b1;
    for (int r = 0; r <= 6; r++)
      exp_q.push_back(ov(r == 0, 1, 0, 0, 0, 0, r, 0, 0, 0, 1));
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      start_i = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL pre_reset: got %h expected %h", obs(), e);
      end
    end
    #2 resetb_i = 1'b0;
    #1;
    n_vec++;
    if (obs() !== 14'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0000", obs());
    end
    @(negedge clock_i);
    resetb_i = 1'b1;
    push_idle(1);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL post_reset_idle: got %h expected %h", obs(), e);
      end
    end
    start_i = 1'b1;
    push_init(0);
    push_wait(1);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      start_i = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL restart_init: got %h expected %h", obs(), e);
      end
    end
  endtask

`ifdef ASCON_AD_SKIP_EN
  task automatic test_ad_skip();
    logic [13:0] e;
    start_i   = 1'b1;
    ad_skip_i = 1'b1;
    push_init(1);
    push_wait(1);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      start_i   = 1'b0;
      ad_skip_i = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL ad_skip_init: got %h expected %h", obs(), e);
      end
    end
    data_valid_i = 1'b1;
    last_i       = 1'b1;
    push_final();
    push_done();
    push_idle(1);
    while (exp_q.size() > 0) begin
      @(negedge clock_i);
      data_valid_i = 1'b0;
      last_i       = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL ad_skip_final: got %h expected %h", obs(), e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_wait_hold();
    test_ad();
    test_pt();
    test_final();
    test_back_to_back();
    test_reset_mid();
    test_reset();
`ifdef ASCON_AD_SKIP_EN
    test_ad_skip();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
